// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared widths, constants and acknowledge-state encoding.
// Revision    : 1.0
// ============================================================================
package pic_pkg;

    localparam int LEVEL_W  = 3;
    localparam int N_LEVELS = 2 ** LEVEL_W;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK1 = 1'b1
    } ack_state_t;

endpackage : pic_pkg
`default_nettype wire

// File: rtl/level_decoder.sv
`default_nettype none
// ============================================================================
// Module      : level_decoder
// Description : Level index to one-hot decode; every input value is legal.
// Revision    : 1.0
// ============================================================================
module level_decoder #(
    parameter int W = 3
) (
    input  logic [W-1:0]      level,
    output logic [(2**W)-1:0] onehot
);

    always_comb begin
        onehot        = '0;
        onehot[level] = 1'b1;
    end

endmodule : level_decoder
`default_nettype wire

// File: rtl/in_service_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : in_service_ctrl
// Description : In-Service Register ownership and two-pulse INTA sequencing.
// Revision    : 1.0
// ============================================================================
module in_service_ctrl
    import pic_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inta_pulse,
    input  logic                int_pending,
    input  logic [LEVEL_W-1:0]  req_level,
    input  logic                aeoi,
    input  logic [4:0]          vec_base,
    input  logic                eoi_strobe,
    input  logic                eoi_specific,
    input  logic [LEVEL_W-1:0]  eoi_level,
    output logic [N_LEVELS-1:0] isr,
    output logic                isr_any,
    output logic [LEVEL_W-1:0]  isr_top_level,
    output logic                ack_busy,
    output logic [7:0]          vector,
    output logic                vector_valid
);

    ack_state_t          r_state, w_state_next;
    logic [LEVEL_W-1:0]  r_level, w_level_next;
    logic                r_spurious, w_spurious_next;
    logic [N_LEVELS-1:0] r_isr;
    logic [7:0]          r_vector;
    logic                r_vector_valid;

    logic [N_LEVELS-1:0] w_req_onehot, w_lat_onehot, w_eoi_onehot;
    logic [N_LEVELS-1:0] w_set_mask, w_clr_mask, w_lowest_onehot;
    logic [LEVEL_W-1:0]  w_lowest_idx;
    logic                w_load_vec;

    // IR0 has highest priority, so scan downward and let the lowest index win.
    function automatic logic [LEVEL_W-1:0] lowest_set(input logic [N_LEVELS-1:0] bits);
        logic [LEVEL_W-1:0] idx;
        idx = '0;
        for (int i = N_LEVELS - 1; i >= 0; i--) begin
            if (bits[i]) idx = LEVEL_W'(i);
        end
        return idx;
    endfunction

    level_decoder #(.W(LEVEL_W)) u_dec_ack  (.level(req_level), .onehot(w_req_onehot));
    level_decoder #(.W(LEVEL_W)) u_dec_aeoi (.level(r_level),   .onehot(w_lat_onehot));
    level_decoder #(.W(LEVEL_W)) u_dec_eoi  (.level(eoi_level), .onehot(w_eoi_onehot));

    assign w_lowest_idx    = lowest_set(r_isr);
    assign w_lowest_onehot = (|r_isr) ? (N_LEVELS'(1) << w_lowest_idx) : '0;

    always_comb begin
        w_state_next    = r_state;
        w_level_next    = r_level;
        w_spurious_next = r_spurious;
        w_set_mask      = '0;
        w_clr_mask      = '0;
        w_load_vec      = 1'b0;

        case (r_state)
            IDLE: begin
                if (inta_pulse) begin
                    w_state_next = ACK1;
                    if (int_pending) begin
                        w_level_next    = req_level;
                        w_spurious_next = 1'b0;
                        w_set_mask      = w_req_onehot;
                    end else begin
                        w_level_next    = SPURIOUS_LEVEL;
                        w_spurious_next = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_pulse) begin
                    w_state_next = IDLE;
                    w_load_vec   = 1'b1;
                    if (aeoi && !r_spurious) w_clr_mask = w_lat_onehot;
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (eoi_strobe) begin
            w_clr_mask = w_clr_mask | (eoi_specific ? w_eoi_onehot : w_lowest_onehot);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_level        <= '0;
            r_spurious     <= 1'b0;
            r_isr          <= '0;
            r_vector       <= 8'h00;
            r_vector_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_level        <= w_level_next;
            r_spurious     <= w_spurious_next;
            // Set wins over clear on the same bit.
            r_isr          <= (r_isr & ~w_clr_mask) | w_set_mask;
            r_vector_valid <= w_load_vec;
            if (w_load_vec) r_vector <= {vec_base, r_level};
        end
    end

    assign isr           = r_isr;
    assign isr_any       = |r_isr;
    assign isr_top_level = w_lowest_idx;
    assign ack_busy      = (r_state == ACK1);
    assign vector        = r_vector;
    assign vector_valid  = r_vector_valid;

endmodule : in_service_ctrl
`default_nettype wire

// File: tb/tb_in_service_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_in_service_ctrl
// Description : Randomized scoreboard bench for in_service_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_in_service_ctrl;

    logic       clk = 1'b0;
    logic       reset, inta_pulse, int_pending, aeoi, eoi_strobe, eoi_specific;
    logic [2:0] req_level, eoi_level;
    logic [4:0] vec_base;
    logic [7:0] isr, vector;
    logic       isr_any, ack_busy, vector_valid;
    logic [2:0] isr_top_level;

    in_service_ctrl dut (
        .clk(clk), .reset(reset), .inta_pulse(inta_pulse), .int_pending(int_pending),
        .req_level(req_level), .aeoi(aeoi), .vec_base(vec_base),
        .eoi_strobe(eoi_strobe), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .isr(isr), .isr_any(isr_any), .isr_top_level(isr_top_level),
        .ack_busy(ack_busy), .vector(vector), .vector_valid(vector_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit started = 0;

    // Reference model state, kept as plain "what the spec says is true now".
    bit [7:0] m_isr;
    bit       m_in_ack, m_spur, m_vv;
    int       m_level;
    bit [7:0] exp_vec_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int lowest_idx(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock cycle: drive inputs, predict, commit prediction after the edge.
    task automatic cyc(input bit rs, input bit ia, input bit pend, input int lvl,
                       input bit ae, input bit [4:0] vb,
                       input bit eoi, input bit sp, input int el);
        bit [7:0] set_m, clr_m, n_isr;
        bit       n_ack, n_spur, n_vv;
        int       n_level;
        bit       push;
        bit [7:0] pv;
        reset = rs; inta_pulse = ia; int_pending = pend; req_level = 3'(lvl);
        aeoi = ae; vec_base = vb; eoi_strobe = eoi; eoi_specific = sp; eoi_level = 3'(el);
        set_m = 0; clr_m = 0; n_ack = m_in_ack; n_spur = m_spur; n_level = m_level;
        n_vv = 0; push = 0; pv = 0;
        if (ia && !m_in_ack) begin
            n_ack = 1;
            if (pend) begin n_level = lvl; n_spur = 0; set_m = 8'(1 << lvl); end
            else begin n_level = 7; n_spur = 1; end
        end else if (ia && m_in_ack) begin
            n_ack = 0; n_vv = 1; push = 1;
            pv = 8'(vb * 8 + m_level);
            if (ae && !m_spur) clr_m = 8'(1 << m_level);
        end
        if (eoi) begin
            if (sp) clr_m = clr_m | 8'(1 << el);
            else if (m_isr != 0) clr_m = clr_m | 8'(1 << lowest_idx(m_isr));
        end
        n_isr = (m_isr & ~clr_m) | set_m;
        @(posedge clk);
        #1;
        if (rs) begin
            m_isr = 0; m_in_ack = 0; m_spur = 0; m_level = 0; m_vv = 0;
        end else begin
            m_isr = n_isr; m_in_ack = n_ack; m_spur = n_spur; m_level = n_level; m_vv = n_vv;
            if (push) exp_vec_q.push_back(pv);
        end
        started = 1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 5'h00, 0, 0, 0);
    endtask

    // Monitor: state-visible outputs every cycle, vectors popped from scoreboard.
    always @(negedge clk) begin
        if (started) begin
            chk("isr", isr, m_isr);
            chk("isr_any", isr_any, (m_isr != 0));
            chk("isr_top_level", isr_top_level, lowest_idx(m_isr));
            chk("ack_busy", ack_busy, m_in_ack);
            chk("vector_valid", vector_valid, m_vv);
            if (vector_valid === 1'b1) begin
                if (exp_vec_q.size() == 0) chk("vector_unexpected", 1, 0);
                else chk("vector", vector, exp_vec_q.pop_front());
            end
        end
    end

    initial begin
        m_isr = 0; m_in_ack = 0; m_spur = 0; m_level = 0; m_vv = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_isr", isr, 8'h00);
        chk("reset_vector", vector, 8'h00);

        // Basic ack at level 3, no AEOI.
        cyc(0, 1, 1, 3, 0, 5'h00, 0, 0, 0);
        chk("ack_l3_isr", isr, 8'h08);
        idle();
        cyc(0, 1, 1, 0, 0, 5'h11, 0, 0, 0);
        chk("ack_l3_vector", vector, 8'h8B);
        chk("ack_l3_isr_hold", isr, 8'h08);
        idle();

        // Same with AEOI.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 3, 1, 5'h00, 0, 0, 0);
        chk("aeoi_between", isr, 8'h08);
        cyc(0, 1, 1, 0, 1, 5'h11, 0, 0, 0);
        chk("aeoi_after", isr, 8'h00);
        idle();

        // Preload levels 2 and 5, then non-specific EOIs.
        cyc(0, 1, 1, 2, 0, 5'h01, 0, 0, 0); cyc(0, 1, 1, 0, 0, 5'h01, 0, 0, 0);
        cyc(0, 1, 1, 5, 0, 5'h01, 0, 0, 0); cyc(0, 1, 1, 0, 0, 5'h01, 0, 0, 0);
        chk("preload", isr, 8'h24);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("nseoi1", isr, 8'h20);
        chk("nseoi1_top", isr_top_level, 3'd5);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("nseoi2", isr, 8'h00);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("nseoi3", isr, 8'h00);

        // Spurious acknowledge with AEOI on.
        cyc(0, 1, 0, 4, 1, 5'h00, 0, 0, 0);
        chk("spur_isr", isr, 8'h00);
        cyc(0, 1, 0, 0, 1, 5'h08, 0, 0, 0);
        chk("spur_vector", vector, 8'h47);
        idle();

        // Same-cycle events.
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_same", isr, 8'h02);
        cyc(0, 1, 1, 1, 0, 0, 1, 1, 1);
        chk("set_wins", isr, 8'h02);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 4, 0, 0, 1, 1, 1);
        chk("eoi_plus_ack", isr, 8'h10);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);

        // Reset mid-sequence.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 6, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ack1_isr", isr, 8'h00);
        chk("rst_ack1_busy", ack_busy, 1'b0);
        cyc(0, 1, 1, 2, 0, 0, 0, 0, 0);
        chk("after_rst_isr", isr, 8'h04);
        chk("after_rst_busy", ack_busy, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) != 0), int'($urandom_range(0, 7)),
                1'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0),
                1'($urandom), int'($urandom_range(0, 7)));
        end
        idle(); idle();
        chk("scoreboard_drained", exp_vec_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_in_service_ctrl
`default_nettype wire
